// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared constants for the group-level leaf switch: flit geometry, routing
// header field positions, port counts and small port-index helpers.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int DATA_W    = 16;
    localparam int HEADER_W  = 6;

    // Routing header fields inside a flit
    localparam int GROUP_MSB = 15;
    localparam int GROUP_LSB = 12;
    localparam int LEAF_MSB  = 11;
    localparam int LEAF_LSB  = 10;

    // Port numbering: leaves 0..3, uplink 4
    localparam int N_LEAF    = 4;
    localparam int UP_IDX    = 4;
    localparam int N_PORT    = 5;

    typedef logic [2:0] port_idx_t;

    // (a + b) modulo N_PORT for port indices already in range
    function automatic port_idx_t port_add(input port_idx_t a, input port_idx_t b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 4'(N_PORT)) begin
            sum = sum - 4'(N_PORT);
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    // Port index following idx, wrapping 4 -> 0
    function automatic port_idx_t next_idx(input port_idx_t idx);
        return port_add(idx, 3'd1);
    endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// -----------------------------------------------------------------------------
// noc_rr_arb
// Five-request round-robin arbiter with a one-hot, same-cycle grant. The
// search starts at the input after the most recently granted one.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset (pointer -> input 0)
//   req[4:0]    - request per input
//   grant[4:0]  - one-hot grant (combinational)
// -----------------------------------------------------------------------------
module noc_rr_arb
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PORT-1:0] req,
    output logic [N_PORT-1:0] grant
);

    port_idx_t         prio_r;
    port_idx_t         grant_idx_s;
    port_idx_t         scan_idx_s;
    logic [N_PORT-1:0] grant_s;
    logic              found_s;

    // Scan requests from the priority pointer; the first requester wins.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = prio_r;
        scan_idx_s  = prio_r;
        found_s     = 1'b0;
        for (int off = 0; off < N_PORT; off++) begin
            scan_idx_s = port_add(prio_r, 3'(off));
            if (!found_s && req[scan_idx_s]) begin
                grant_s[scan_idx_s] = 1'b1;
                grant_idx_s         = scan_idx_s;
                found_s             = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Advance the priority pointer past the winner whenever a grant is made.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r <= 3'd0;
        end else if (found_s) begin
            prio_r <= next_idx(grant_idx_s);
        end else begin
            prio_r <= prio_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/leaf_switch.sv
// -----------------------------------------------------------------------------
// leaf_switch
// Group-level switch: four leaf ports (one per GPU network interface) and one
// spine uplink. Every input has a FIFO; each FIFO head is routed by its header
// (group [15:12], leaf [11:10]) to a leaf output or the uplink, and each output
// owns a round-robin arbiter. Uplink flits not addressed to this group are
// discarded as misroutes.
// Configuration macro: LEAF_SWITCH_STATS_EN - when defined, drop_count is a
// saturating counter of leaf overflows and misroutes; otherwise it reads 0.
// Ports:
//   clk, reset                      - clock, asynchronous active-low reset
//   leaf_in_data/valid/ready        - leaf ingress; ready is a credit seen one
//                                     cycle ahead by the network interface
//   leaf_out_data/valid             - leaf egress, single-cycle pulse, no stall
//   up_in_data/valid/ready          - spine ingress, same-cycle handshake
//   up_out_data/valid/ready         - spine egress, registered valid/ready
//   drop_count                      - dropped flit count (saturating)
// -----------------------------------------------------------------------------
module leaf_switch #(
    parameter logic [3:0] GROUP_ID   = 4'd1,
    parameter int         DATA_W     = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DATA_W-1:0] leaf_in_data,
    input  logic [3:0]          leaf_in_valid,
    output logic [3:0]          leaf_in_ready,
    output logic [4*DATA_W-1:0] leaf_out_data,
    output logic [3:0]          leaf_out_valid,
    input  logic [DATA_W-1:0]   up_in_data,
    input  logic                up_in_valid,
    output logic                up_in_ready,
    output logic [DATA_W-1:0]   up_out_data,
    output logic                up_out_valid,
    input  logic                up_out_ready,
    output logic [15:0]         drop_count
);
    import noc_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_r    [N_PORT][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r [N_PORT];
    logic [PTR_W-1:0]  rd_ptr_r [N_PORT];
    logic [CNT_W-1:0]  count_r  [N_PORT];

    logic [DATA_W-1:0] in_data_s  [N_PORT];
    logic [DATA_W-1:0] head_s     [N_PORT];
    port_idx_t         dest_s     [N_PORT];
    logic [DATA_W-1:0] sel_data_s [N_PORT];
    logic [N_PORT-1:0] in_valid_s, push_s, pop_s, nonempty_s, local_s;
    logic [N_PORT-1:0][N_PORT-1:0] req_s;    // [output][input]
    logic [N_PORT-1:0][N_PORT-1:0] grant_s;  // [output][input]
    logic              misroute_s;
    logic              up_free_s;

    logic [4*DATA_W-1:0] leaf_out_data_r;
    logic [3:0]          leaf_out_valid_r;
    logic [DATA_W-1:0]   up_out_data_r;
    logic                up_out_valid_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Gather the five ingress streams and decide which ones are written.
    // Leaf writes use count before any same-cycle pop, so a pop never
    // makes room for a leaf flit in that same cycle.
    always_comb begin
        for (int i = 0; i < N_LEAF; i++) begin
            in_data_s[i]  = leaf_in_data[i*DATA_W +: DATA_W];
            in_valid_s[i] = leaf_in_valid[i];
        end
        in_data_s[UP_IDX]  = up_in_data;
        in_valid_s[UP_IDX] = up_in_valid;
        for (int i = 0; i < N_PORT; i++) begin
            push_s[i] = in_valid_s[i] && (count_r[i] < CNT_W'(FIFO_DEPTH));
        end
    end

    // Decode each FIFO head into a destination port.
    always_comb begin
        for (int i = 0; i < N_PORT; i++) begin
            head_s[i]     = mem_r[i][rd_ptr_r[i]];
            nonempty_s[i] = (count_r[i] != '0);
            local_s[i]    = (head_s[i][GROUP_MSB:GROUP_LSB] == GROUP_ID);
            dest_s[i]     = local_s[i] ? {1'b0, head_s[i][LEAF_MSB:LEAF_LSB]} : 3'(UP_IDX);
        end
        misroute_s = nonempty_s[UP_IDX] && !local_s[UP_IDX];
        up_free_s  = !up_out_valid_r || up_out_ready;
    end

    // Requests per output; the uplink never requests itself (that is a
    // misroute) and the uplink output only arbitrates when it can load.
    always_comb begin
        req_s = '0;
        for (int o = 0; o < N_PORT; o++) begin
            for (int i = 0; i < N_PORT; i++) begin
                req_s[o][i] = nonempty_s[i] && (dest_s[i] == 3'(o)) &&
                              ((o != UP_IDX) || ((i != UP_IDX) && up_free_s));
            end
        end
    end

    for (genvar o = 0; o < N_PORT; o++) begin : g_arb
        noc_rr_arb u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req_s[o]),
            .grant (grant_s[o])
        );
    end

    // Pop on any grant, or on a misrouted uplink head; select winner data.
    always_comb begin
        pop_s = '0;
        for (int o = 0; o < N_PORT; o++) begin
            sel_data_s[o] = '0;
            for (int i = 0; i < N_PORT; i++) begin
                pop_s[i] = pop_s[i] | grant_s[o][i];
                if (grant_s[o][i]) begin
                    sel_data_s[o] = sel_data_s[o] | head_s[i];
                end else begin
                    sel_data_s[o] = sel_data_s[o];
                end
            end
        end
        pop_s[UP_IDX] = pop_s[UP_IDX] | misroute_s;
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORT; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PORT; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORT; i++) begin
                wr_ptr_r[i] <= push_s[i] ? ptr_inc(wr_ptr_r[i]) : wr_ptr_r[i];
                rd_ptr_r[i] <= pop_s[i]  ? ptr_inc(rd_ptr_r[i]) : rd_ptr_r[i];
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
                    2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Leaf egress: one-cycle pulse per grant, data holds between grants.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leaf_out_data_r  <= '0;
            leaf_out_valid_r <= 4'h0;
        end else begin
            for (int o = 0; o < N_LEAF; o++) begin
                if (|grant_s[o]) begin
                    leaf_out_data_r[o*DATA_W +: DATA_W] <= sel_data_s[o];
                    leaf_out_valid_r[o]                 <= 1'b1;
                end else begin
                    leaf_out_valid_r[o] <= 1'b0;
                end
            end
        end
    end

    // Uplink egress: holds while the spine stalls, reloads when free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_out_data_r  <= '0;
            up_out_valid_r <= 1'b0;
        end else if (up_free_s) begin
            if (|grant_s[UP_IDX]) begin
                up_out_data_r  <= sel_data_s[UP_IDX];
                up_out_valid_r <= 1'b1;
            end else begin
                up_out_valid_r <= 1'b0;
            end
        end else begin
            up_out_valid_r <= up_out_valid_r;
        end
    end

`ifdef LEAF_SWITCH_STATS_EN
    logic [N_LEAF-1:0] leaf_drop_s;
    logic [2:0]        drop_num_s;
    logic [16:0]       drop_sum_s;
    logic [15:0]       drop_count_r;

    // Count this cycle's drops: leaf flits that found no space plus misroutes.
    always_comb begin
        drop_num_s = {2'b00, misroute_s};
        for (int i = 0; i < N_LEAF; i++) begin
            leaf_drop_s[i] = leaf_in_valid[i] && !push_s[i];
            drop_num_s     = drop_num_s + {2'b00, leaf_drop_s[i]};
        end
        drop_sum_s = {1'b0, drop_count_r} + {14'd0, drop_num_s};
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_r <= 16'h0000;
        end else if (drop_sum_s[16]) begin
            drop_count_r <= 16'hFFFF;
        end else begin
            drop_count_r <= drop_sum_s[15:0];
        end
    end

    assign drop_count = drop_count_r;
`else
    assign drop_count = 16'h0000;
`endif

    for (genvar i = 0; i < N_LEAF; i++) begin : g_credit
        assign leaf_in_ready[i] = (count_r[i] <= CNT_W'(FIFO_DEPTH - 2));
    end
    assign up_in_ready    = (count_r[UP_IDX] < CNT_W'(FIFO_DEPTH));
    assign leaf_out_data  = leaf_out_data_r;
    assign leaf_out_valid = leaf_out_valid_r;
    assign up_out_data    = up_out_data_r;
    assign up_out_valid   = up_out_valid_r;

endmodule

// File: tb/tb_leaf_switch.sv
// -----------------------------------------------------------------------------
// tb_leaf_switch
// Directed bench for leaf_switch. Stimulus pushes the expected flit into a
// queue per (output, source); an independent monitor pops and compares each
// delivered flit. Exact timing and drop_count are checked inline.
// -----------------------------------------------------------------------------
module tb_leaf_switch;

`ifdef LEAF_SWITCH_STATS_EN
    localparam logic [15:0] EXP_DROP = 16'd1;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] leaf_in_data;
    logic [3:0]  leaf_in_valid;
    logic [3:0]  leaf_in_ready;
    logic [63:0] leaf_out_data;
    logic [3:0]  leaf_out_valid;
    logic [15:0] up_in_data;
    logic        up_in_valid;
    logic        up_in_ready;
    logic [15:0] up_out_data;
    logic        up_out_valid;
    logic        up_out_ready;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q [5][5][$];   // [output][source]
    logic [15:0] got2_q [$];        // arrival log of leaf output 2

    always #5 clk = ~clk;

    leaf_switch dut (
        .clk            (clk),
        .reset          (reset),
        .leaf_in_data   (leaf_in_data),
        .leaf_in_valid  (leaf_in_valid),
        .leaf_in_ready  (leaf_in_ready),
        .leaf_out_data  (leaf_out_data),
        .leaf_out_valid (leaf_out_valid),
        .up_in_data     (up_in_data),
        .up_in_valid    (up_in_valid),
        .up_in_ready    (up_in_ready),
        .up_out_data    (up_out_data),
        .up_out_valid   (up_out_valid),
        .up_out_ready   (up_out_ready),
        .drop_count     (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Match a delivered flit against the head of some source queue of output o
    task automatic match(input int o, input logic [15:0] d);
        bit found = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (!found && exp_q[o][s].size() > 0 && exp_q[o][s][0] == d) begin
                void'(exp_q[o][s].pop_front());
                found = 1'b1;
            end
        end
        if (o == 2) got2_q.push_back(d);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL out%0d_flit: got 0x%04h expected a queued flit (none matches)", o, d);
        end
    endtask

    // Monitor: sample away from the rising edge
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int o = 0; o < 4; o++) begin
                if (leaf_out_valid[o]) match(o, leaf_out_data[o*16 +: 16]);
            end
            if (up_out_valid && up_out_ready) match(4, up_out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_leaf(input int i, input logic [15:0] d);
        leaf_in_data[i*16 +: 16] = d;
        leaf_in_valid[i]         = 1'b1;
    endtask

    initial begin
        logic [15:0] cont_exp [6];
        int  lk, uk;
        bit  saw_low, rdy, up_acc;
        int  pend;

        reset         = 1'b0;
        leaf_in_data  = '0;
        leaf_in_valid = 4'h0;
        up_in_data    = 16'h0000;
        up_in_valid   = 1'b0;
        up_out_ready  = 1'b1;
        idle(3);
        reset = 1'b1;
        tick();

        // Reset state
        check("rst_leaf_in_ready", leaf_in_ready, 4'hF);
        check("rst_up_in_ready", up_in_ready, 1'b1);
        check("rst_leaf_out_valid", leaf_out_valid, 4'h0);
        check("rst_leaf_out_data", leaf_out_data[31:0] | leaf_out_data[63:32], 32'h0);
        check("rst_up_out", {up_out_valid, up_out_data}, 17'h0);
        check("rst_drop_count", drop_count, 16'h0);

        // Contention: leaves 0,1,3 -> leaf 2, two rounds, order 0,1,3 each
        cont_exp = '{16'h1810, 16'h1811, 16'h1813, 16'h1820, 16'h1821, 16'h1823};
        for (int r = 0; r < 2; r++) begin
            send_leaf(0, cont_exp[r*3 + 0]); exp_q[2][0].push_back(cont_exp[r*3 + 0]);
            send_leaf(1, cont_exp[r*3 + 1]); exp_q[2][1].push_back(cont_exp[r*3 + 1]);
            send_leaf(3, cont_exp[r*3 + 2]); exp_q[2][3].push_back(cont_exp[r*3 + 2]);
            tick();
            leaf_in_valid = 4'h0;
            idle(5);
        end
        check("contention_count", got2_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("contention_order%0d", k),
                  (got2_q.size() > k) ? got2_q[k] : 16'hDEAD, cont_exp[k]);
        end

        // Local delivery: leaf 0 -> group 1 leaf 2, valid after second edge
        send_leaf(0, 16'h1A05); exp_q[2][0].push_back(16'h1A05);
        tick();
        leaf_in_valid = 4'h0;
        tick();
        check("local_valid", leaf_out_valid, 4'b0100);
        check("local_data", leaf_out_data[47:32], 16'h1A05);
        check("local_up_idle", up_out_valid, 1'b0);
        tick();
        check("local_pulse_end", leaf_out_valid, 4'h0);
        idle(2);

        // Uplink routing with backpressure
        up_out_ready = 1'b0;
        send_leaf(1, 16'h2C33); exp_q[4][1].push_back(16'h2C33);
        tick();
        leaf_in_valid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("bp_hold%0d", k), {up_out_valid, up_out_data}, {1'b1, 16'h2C33});
        end
        up_out_ready = 1'b1;
        tick();
        check("bp_release", up_out_valid, 1'b0);
        idle(2);

        // Credit: leaf 0 obeys credit, uplink floods the same output (leaf 2)
        lk = 0; uk = 0; saw_low = 1'b0; up_acc = 1'b0;
        up_in_data  = 16'h1B00;
        up_in_valid = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (!leaf_in_ready[0]) saw_low = 1'b1;
            if (leaf_in_valid[0]) begin
                exp_q[2][0].push_back(leaf_in_data[15:0]);
                lk++;
            end
            up_acc = up_in_valid && up_in_ready;
            if (up_acc) begin
                exp_q[2][4].push_back(up_in_data);
                uk++;
            end
            rdy = leaf_in_ready[0];
            tick();
            leaf_in_valid[0]   = rdy && (cyc < 20);
            leaf_in_data[15:0] = 16'h1900 | 16'(lk);
            if (up_acc) up_in_data = 16'h1B00 | 16'(uk);
            up_in_valid = (cyc < 20);
        end
        leaf_in_valid = 4'h0;
        up_in_valid   = 1'b0;
        idle(20);
        check("credit_ready_low", saw_low, 1'b1);
        check("credit_no_drop", drop_count, 16'h0);

        // Overflow: uplink stalled, leaf 0 forces 6 flits; the 6th is dropped
        up_out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_leaf(0, 16'h2100 | 16'(k));
            if (k < 5) exp_q[4][0].push_back(16'h2100 | 16'(k));
            tick();
        end
        leaf_in_valid = 4'h0;
        tick();
        check("overflow_ready_low", leaf_in_ready[0], 1'b0);
        check("overflow_drop", drop_count, EXP_DROP);
        up_out_ready = 1'b1;
        idle(10);

        // Reset with three flits buffered (one in the uplink register)
        up_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_leaf(1, 16'h2200 | 16'(k));
            tick();
        end
        leaf_in_valid = 4'h0;
        tick();
        check("pre_reset_up_valid", up_out_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_leaf_out", {leaf_out_valid, leaf_out_data}, 68'h0);
        check("midrst_up_out", {up_out_valid, up_out_data}, 17'h0);
        check("midrst_drop", drop_count, 16'h0);
        idle(2);
        reset = 1'b1;
        up_out_ready = 1'b1;
        tick();
        check("postrst_leaf_in_ready", leaf_in_ready, 4'hF);
        check("postrst_up_in_ready", up_in_ready, 1'b1);
        idle(8);

        // Misroute: uplink flit for group 3 is discarded
        up_in_data  = 16'h3000;
        up_in_valid = 1'b1;
        tick();
        up_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("misroute_idle%0d", k), {leaf_out_valid, up_out_valid}, 5'h0);
        end
        check("misroute_drop", drop_count, EXP_DROP);

        // Every expected flit must have been delivered
        for (int o = 0; o < 5; o++) begin
            pend = 0;
            for (int s = 0; s < 5; s++) pend += exp_q[o][s].size();
            check($sformatf("pending_out%0d", o), pend, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
